// File: rtl/priority_encode_unit_pkg.sv
// ---------------------------------------------------------------------------
// priority_encode_unit_pkg
//
// Shared types for the pipelined priority encoder. Used by the divider
// normalisation path and the bit-manipulation unit.
//
// Contents:
//   pe_mode_t       operation select (MSB_IDX, LSB_IDX, CLZ, CTZ)
//   pe_stage1_t     registered result of the segment scan stage
//   pe_mode_is_msb  true for modes that search from the top of the operand
//
// pe_stage1_t is sized for the largest supported configuration
// (WIDTH=64 split into 2-bit segments, 32-bit segments, 8-bit tags).
// Smaller instances fill only the low entries and leave the rest zero.
// ---------------------------------------------------------------------------
package priority_encode_unit_pkg;

    localparam int PE_MAX_SEGS  = 32;
    localparam int PE_MAX_IDX_W = 5;
    localparam int PE_MAX_ID_W  = 8;

    typedef enum logic [1:0] {
        MSB_IDX = 2'd0,
        LSB_IDX = 2'd1,
        CLZ     = 2'd2,
        CTZ     = 2'd3
    } pe_mode_t;

    typedef struct packed {
        logic [PE_MAX_SEGS-1:0]                   found;
        logic [PE_MAX_SEGS-1:0][PE_MAX_IDX_W-1:0] hi_idx;
        logic [PE_MAX_SEGS-1:0][PE_MAX_IDX_W-1:0] lo_idx;
        pe_mode_t                                 mode;
        logic [PE_MAX_ID_W-1:0]                   id;
    } pe_stage1_t;

    // CLZ is derived from the highest set bit, CTZ from the lowest.
    function automatic logic pe_mode_is_msb(input pe_mode_t mode);
        return (mode == MSB_IDX) || (mode == CLZ);
    endfunction

endpackage

// File: rtl/priority_encode_unit_scan.sv
// ---------------------------------------------------------------------------
// segment_priority_scan
//
// Combinational scan of one SEG_WIDTH-bit slice of the operand.
//
// Ports:
//   seg_data  in   SEG_WIDTH          slice of the operand
//   found     out  1                  any bit of the slice is set
//   hi_idx    out  $clog2(SEG_WIDTH)  index of the highest set bit
//   lo_idx    out  $clog2(SEG_WIDTH)  index of the lowest set bit
//
// hi_idx and lo_idx read 0 when found is 0; the selector ignores them then.
// ---------------------------------------------------------------------------
module segment_priority_scan #(
    parameter int SEG_WIDTH = 8
) (
    input  logic [SEG_WIDTH-1:0]         seg_data,
    output logic                         found,
    output logic [$clog2(SEG_WIDTH)-1:0] hi_idx,
    output logic [$clog2(SEG_WIDTH)-1:0] lo_idx
);

    localparam int IW = $clog2(SEG_WIDTH);

    // The ascending loop leaves the last (highest) set bit in hi_idx and the
    // descending loop leaves the last (lowest) set bit in lo_idx.
    always_comb begin
        found  = |seg_data;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            if (seg_data[i]) begin
                hi_idx = IW'(i);
            end
        end
        for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
            if (seg_data[i]) begin
                lo_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encode_unit.sv
// ---------------------------------------------------------------------------
// priority_encode_unit
//
// Two-stage pipelined priority encoder with valid/ready handshakes and tag
// passthrough. Stage 1 scans WIDTH/SEG_WIDTH segments in parallel and
// registers per-segment results; stage 2 picks the winning segment, forms
// the bit index and applies the mode transform into the output register.
//
// Parameters:
//   WIDTH      operand width, power of two, 8..64
//   SEG_WIDTH  segment width, power of two, >=2, WIDTH/SEG_WIDTH >= 2
//   ID_W       tag width, at most 8
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   in_valid    operand present
//   in_ready    operand accepted this cycle
//   in_data     operand
//   in_mode     0=MSB_IDX 1=LSB_IDX 2=CLZ 3=CTZ
//   in_id       tag, returned unchanged with the result
//   out_valid   result present
//   out_ready   consumer accepts the result
//   out_result  result, zero-extended to RW bits
//   out_zero    operand was all zeros
//   out_id      tag of this result
//
// For a zero operand the index modes return 0 and the count modes return
// WIDTH, which is why the result carries one bit more than an index needs.
// ---------------------------------------------------------------------------
module priority_encode_unit
    import priority_encode_unit_pkg::*;
#(
    parameter  int WIDTH     = 32,
    parameter  int SEG_WIDTH = 8,
    parameter  int ID_W      = 3,
    localparam int RW        = $clog2(WIDTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]      in_mode,
    input  logic [ID_W-1:0] in_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_result,
    output logic            out_zero,
    output logic [ID_W-1:0] out_id
);

    localparam int N  = WIDTH / SEG_WIDTH;
    localparam int IW = $clog2(SEG_WIDTH);

    logic [N-1:0]         seg_found;
    logic [N-1:0][IW-1:0] seg_hi;
    logic [N-1:0][IW-1:0] seg_lo;

    pe_stage1_t s1_d;
    pe_stage1_t s1_q;
    logic       s1_valid;
    logic       s2_ready;
    logic       in_fire;

    logic          any_found;
    logic [RW-1:0] msb_pos;
    logic [RW-1:0] lsb_pos;
    logic [RW-1:0] sel_pos;
    logic [RW-1:0] s2_result;

    // ------------------------------------------------------------------
    // Stage 1: parallel segment scan
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N; g++) begin : g_seg
        segment_priority_scan #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_scan (
            .seg_data (in_data[g*SEG_WIDTH +: SEG_WIDTH]),
            .found    (seg_found[g]),
            .hi_idx   (seg_hi[g]),
            .lo_idx   (seg_lo[g])
        );
    end

    // Handshake. The output register frees up when it is empty or being
    // drained; stage 1 can take a new operand when it is empty or moving on.
    // in_ready never looks at in_valid, so there is no valid->ready path.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || s2_ready);
    assign in_fire  = in_valid && in_ready;

    // Pack the scan results into the shared stage-1 record; entries beyond
    // N stay zero.
    always_comb begin
        s1_d      = '0;
        s1_d.mode = pe_mode_t'(in_mode);
        s1_d.id   = PE_MAX_ID_W'(in_id);
        for (int g = 0; g < N; g++) begin
            s1_d.found[g]  = seg_found[g];
            s1_d.hi_idx[g] = PE_MAX_IDX_W'(seg_hi[g]);
            s1_d.lo_idx[g] = PE_MAX_IDX_W'(seg_lo[g]);
        end
    end

    // Stage-1 register. Whenever in_ready is high the current contents are
    // either absent or leaving, so the valid bit simply follows in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (in_fire) begin
                s1_q <= s1_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: segment selection and mode transform
    // ------------------------------------------------------------------
    // Ascending scan keeps the highest found segment, descending keeps the
    // lowest; both positions stay 0 for an all-zero operand.
    always_comb begin
        any_found = 1'b0;
        msb_pos   = '0;
        lsb_pos   = '0;
        for (int i = 0; i < N; i++) begin
            if (s1_q.found[i]) begin
                any_found = 1'b1;
                msb_pos   = RW'(i * SEG_WIDTH) + RW'(s1_q.hi_idx[i]);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (s1_q.found[i]) begin
                lsb_pos = RW'(i * SEG_WIDTH) + RW'(s1_q.lo_idx[i]);
            end
        end
    end

    always_comb begin
        sel_pos   = pe_mode_is_msb(s1_q.mode) ? msb_pos : lsb_pos;
        s2_result = sel_pos;
        case (s1_q.mode)
            CLZ:     s2_result = any_found ? (RW'(WIDTH - 1) - sel_pos) : RW'(WIDTH);
            CTZ:     s2_result = any_found ? sel_pos : RW'(WIDTH);
            default: s2_result = sel_pos;
        endcase
    end

    // Output register. Data only loads when a real operation moves in, so
    // a held result stays stable while the consumer is stalling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_id     <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= s2_result;
                out_zero   <= !any_found;
                out_id     <= s1_q.id[ID_W-1:0];
            end
        end
    end

    // Stage-1 record entries above N and tag bits above ID_W exist only to
    // fit the largest configuration.
    logic unused_s1_bits;
    assign unused_s1_bits = ^s1_q;

endmodule

// File: doc/priority_encode_unit.md
# priority_encode_unit

Pipelined, parametrised priority encoder. Returns the most-significant or least-significant set-bit index, or the leading- or trailing-zero count, of a WIDTH-bit operand. It has a valid/ready handshake and an ID tag passthrough. It serves the divider normalisation path and the bit-manipulation unit, and replaces single-cycle combinational MSB finders on timing-critical paths.

## Interface
- WIDTH, 32: operand width. Power of two, 8..64.
- SEG_WIDTH, 8: segment width for the parallel scan. Power of two; must divide WIDTH; WIDTH/SEG_WIDTH ≥ 2.
- ID_W, 3: tag width.
- RW (localparam): $clog2(WIDTH)+1.
- clk  in  1  clock. One clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  unit accepts the operand this cycle.
- in_data  in  WIDTH  operand.
- in_mode  in  2  0=MSB_IDX, 1=LSB_IDX, 2=CLZ, 3=CTZ.
- in_id  in  ID_W  tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  RW  result, zero-extended.
- out_zero  out  1  operand was all zeros.
- out_id  out  ID_W  tag of this result.

## Operation
- Transfer occurs when valid && ready, on either port.
- Stage 1, scan:
  - Split the operand into N = WIDTH/SEG_WIDTH segments.
  - Per segment: found flag (OR of its bits), highest set index, lowest set index (each $clog2(SEG_WIDTH) bits).
  - Register the segment results, mode and id.
- Stage 2, select:
  - MSB modes: pick the highest segment with found=1. LSB modes: pick the lowest.
  - Index = segment_number*SEG_WIDTH + sub-index.
  - Transform: MSB_IDX → msb; LSB_IDX → lsb; CLZ → WIDTH-1-msb; CTZ → lsb.
  - Register to the outputs.
- Zero operand:
  - out_zero=1.
  - MSB_IDX/LSB_IDX → 0; CLZ/CTZ → WIDTH (the reason RW has an extra bit).
- Arithmetic is unsigned in RW bits. No overflow is possible.
- Ordering: results leave in acceptance order. No reordering, drops or duplicates.

## Timing
- Latency: 2 cycles from an input transfer to out_valid, when there is no backpressure.
- Throughput: one operation per cycle while out_ready=1.
- Stall logic:
  - s2_ready = !out_valid || out_ready.
  - s1 advances when s2_ready.
  - in_ready = !rst && (!s1_valid || s2_ready).
  - in_ready is combinational from internal state and out_ready; there is no path from in_valid to in_ready.
- Stall behaviour:
  - With out_ready held low, the unit absorbs 2 operations, then in_ready=0.
  - out_result, out_zero and out_id stay stable while out_valid && !out_ready.
- Simultaneous events: a pop at the output and a push at the input in the same cycle, with a full pipe, transfer both. No bubble is inserted.
- Reset values: out_valid=0, s1_valid=0, out_result=0, out_zero=0, out_id=0. in_ready=0 while rst is asserted and 1 on the first cycle after deassertion.
- Reset mid-operation: all in-flight operations are discarded and no result is emitted for them. Data registers may be left unreset only if they are guarded by their valid bit; outputs must still read 0 after reset.
- Bench requirement: inputs must be held stable while in_valid && !in_ready; the bench asserts this.

## Structure
- Shared package (used by the divider and the bit-manipulation unit):
  - typedef enum logic [1:0] pe_mode_t {MSB_IDX, LSB_IDX, CLZ, CTZ}.
  - Stage-1 struct type: found vector, sub-index arrays, mode, id.
- One sub-module, segment_priority_scan:
  - Parameter SEG_WIDTH; combinational.
  - Outputs found, hi_idx and lo_idx for one segment.
  - Instantiated N times in a generate loop.
- Top level holds the two pipeline registers, the handshake logic and the stage-2 selection.

## Test plan
- Defaults, operand 0x0001_0000, MSB_IDX, id=5 → out_result=16, out_zero=0, out_id=5, out_valid exactly 2 cycles after acceptance.
- Operand 0x8000_0001 in modes 0..3, back-to-back → results 31, 0, 0, 0 on consecutive cycles.
- Operand 0x0000_0000 in modes 0..3 → 0, 0, 32, 32 with out_zero=1 for each.
- out_ready=0 for 6 cycles while 4 operations are offered back-to-back → in_ready falls after 2 accepts; the held result is stable. After out_ready=1, all 4 results arrive in id order, none lost.
- rst pulsed while 2 operations are in flight → out_valid=0 immediately (asynchronous) and no stale result appears. A fresh operand, 0x0000_00F0 CTZ, then yields 4.
- WIDTH=64, SEG_WIDTH=16, operand 0x0000_0400_0000_0000 → MSB_IDX 42, CLZ 21, LSB_IDX 42, CTZ 42.
